// File: rtl/ux607_dlm_ctrl_pkg.sv
// Shared types and default sizing for the DLM RAM initiator controller.
// Light-sleep build option: UX607_DLM_CTRL_LS_EN.
package ux607_dlm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  localparam int DLM_DP         = 65536;
  localparam int DLM_AW         = 16;
  localparam int DLM_DW         = 64;
  localparam int DLM_MW         = 8;
  localparam int DLM_IDLE_CYC   = 16;
  localparam int RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/ux607_dlm_rsp_fifo.sv
// Two-entry response FIFO; push and pop may occur in the same cycle.
module ux607_dlm_rsp_fifo
  import ux607_dlm_ctrl_pkg::*;
#(
  parameter int W = DLM_DW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [RSP_FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_pop;

  // Popping an empty FIFO is ignored so the count can never wrap.
  assign w_pop = i_pop && (r_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/ux607_dlm_ctrl.sv
// DLM RAM initiator: command bus to RAM port, 2-cycle response via 2-entry FIFO.
// Optional light-sleep FSM enabled by `define UX607_DLM_CTRL_LS_EN.
module ux607_dlm_ctrl
  import ux607_dlm_ctrl_pkg::*;
#(
  parameter int DP       = DLM_DP,
  parameter int AW       = DLM_AW,
  parameter int DW       = DLM_DW,
  parameter int MW       = DLM_MW,
  parameter int IDLE_CYC = DLM_IDLE_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);

  logic          w_acc;
  logic          w_in_range;
  logic          w_pop;
  logic          w_run;
  logic [1:0]    w_cnt;
  logic [2:0]    w_occ;
  logic [DW:0]   w_push_data;
  logic [DW:0]   w_head;
  logic          r_pend;
  logic          r_pend_read;
  logic          r_pend_err;

  assign w_in_range = (32'(cmd_addr) < 32'(DP));
  assign w_pop      = rsp_valid && rsp_ready;
  // Slots already committed: buffered entries plus the in-flight access, minus a same-cycle pop.
  assign w_occ      = {1'b0, w_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
  assign cmd_ready  = w_run && (w_occ < 3'd2);
  assign w_acc      = cmd_valid && cmd_ready;

  assign ram_cs   = w_acc && w_in_range;
  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_wdata;
  assign ram_wem  = cmd_read ? '0 : cmd_wmask;
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_read <= 1'b0;
      r_pend_err  <= 1'b0;
    end else begin
      r_pend <= w_acc;
      if (w_acc) begin
        r_pend_read <= cmd_read;
        r_pend_err  <= !w_in_range;
      end
    end
  end

  assign w_push_data = {(r_pend_read && !r_pend_err) ? ram_dout : '0, r_pend_err};

  ux607_dlm_rsp_fifo #(.W(DW + 1)) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pend),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_data      (w_head),
    .o_cnt       (w_cnt)
  );

  assign rsp_valid = (w_cnt != 2'd0);
  assign rsp_rdata = w_head[DW:1];
  assign rsp_err   = w_head[0];

`ifdef UX607_DLM_CTRL_LS_EN
  // state  | meaning
  // RUN    | normal operation, idle counter running
  // SLEEP  | RAM in light sleep, commands held off
  // WAKE   | one-cycle exit from light sleep
  localparam int CW = $clog2(IDLE_CYC + 1);

  state_t          r_state;
  logic [CW-1:0]   r_idle_cnt;
  logic            r_ls;
  logic            w_idle;

  assign w_idle = !cmd_valid && !r_pend && (w_cnt == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_ls       <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!w_idle) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == CW'(IDLE_CYC - 1)) begin
            r_state    <= ST_SLEEP;
            r_ls       <= 1'b1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
          end
        end
        ST_SLEEP: begin
          if (cmd_valid) begin
            r_state <= ST_WAKE;
            r_ls    <= 1'b0;
          end
        end
        ST_WAKE: r_state <= ST_RUN;
        default: begin
          r_state <= ST_RUN;
          r_ls    <= 1'b0;
        end
      endcase
    end
  end

  assign w_run  = (r_state == ST_RUN);
  assign ram_ls = r_ls;
`else
  assign w_run  = 1'b1;
  assign ram_ls = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_dlm_ctrl.sv
// Scoreboard bench for ux607_dlm_ctrl with a behavioural RAM and shadow memory.
// Light-sleep checks are built only with UX607_DLM_CTRL_LS_EN.
module tb_ux607_dlm_ctrl;

  localparam int DP = 4096;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs, ram_ls, ram_ds, ram_sd;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;

  ux607_dlm_ctrl #(.DP(DP), .AW(AW), .DW(DW), .MW(MW), .IDLE_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ram_mem [DP];
  logic [DW-1:0] shadow  [DP];
  int            n_vec = 0, n_err = 0;
  int            cyc = 0, n_acc = 0, n_cs = 0;
  bit            lat_chk = 1'b1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_cs) begin
      ram_dout <= ram_mem[ram_addr[11:0]];
      for (int i = 0; i < MW; i++)
        if (ram_wem[i]) ram_mem[ram_addr[11:0]][i*8 +: 8] <= ram_din[i*8 +: 8];
    end
  end

  // Monitor: record accepts into the scoreboard, compare responses on pop.
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (ram_cs) n_cs++;
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        x.c = cyc;
        x.d = '0;
        x.e = 1'b0;
        if (32'(cmd_addr) >= DP) begin
          x.e = 1'b1;
          chk("cs_oor", {63'd0, ram_cs}, 64'd0);
        end else begin
          chk("cs_inr", {63'd0, ram_cs}, 64'd1);
          if (cmd_read) x.d = shadow[cmd_addr[11:0]];
          else shadow[cmd_addr[11:0]] = merge(shadow[cmd_addr[11:0]], cmd_wdata, cmd_wmask);
        end
        sb.push_back(x);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexp", 64'd1, 64'd0);
        end else begin
          x = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, x.d);
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, x.e});
          if (lat_chk) chk("rsp_lat", 64'(cyc - x.c), 64'd2);
        end
      end
    end
  end

  // Called just after a posedge; holds the command until accepted.
  task automatic send(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] m);
    int t;
    bit done;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m;
    t = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
      else if (++t > 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, c0, s0;
    for (int i = 0; i < DP; i++) begin ram_mem[i] = '0; shadow[i] = '0; end
    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_ram_ls", {63'd0, ram_ls}, 64'd0);
    chk("rst_ram_cs", {63'd0, ram_cs}, 64'd0);
    chk("ds_sd", {62'd0, ram_ds, ram_sd}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;

    // Basic write/read and partial masks.
    send(1'b0, 16'h0010, 64'h1122334455667788, 8'hFF);
    send(1'b1, 16'h0010, '0, 8'h00);
    send(1'b0, 16'h0000, {64{1'b1}}, 8'h0F);
    send(1'b1, 16'h0000, '0, 8'h00);
    send(1'b0, 16'h0010, {64{1'b1}}, 8'h00);
    send(1'b1, 16'h0010, '0, 8'h00);
    drain();
    chk("mask_shadow", shadow[0], 64'h00000000FFFFFFFF);

    // Back-to-back writes then reads.
    for (int i = 0; i < 8; i++) send(1'b0, 16'(16'h0100 + i), {$urandom, $urandom}, 8'hFF);
    drain();
    a0 = n_acc; c0 = cyc; s0 = n_cs;
    for (int i = 0; i < 8; i++) send(1'b1, 16'(16'h0100 + i), '0, 8'h00);
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);
    chk("b2b_accepts", 64'(n_acc - a0), 64'd8);
    chk("b2b_cs_cycles", 64'(n_cs - s0), 64'd8);
    drain();

    // Response-side stall: only two accepts fit.
    lat_chk = 1'b0;
    a0 = n_acc;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h0103;
    repeat (8) @(posedge clk);
    #1;
    chk("stall_accepts", 64'(n_acc - a0), 64'd2);
    @(negedge clk);
    chk("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    drain();
    lat_chk = 1'b1;
    send(1'b1, 16'h0104, '0, 8'h00);
    drain();

    // Out-of-range read and write.
    send(1'b1, 16'(DP), '0, 8'h00);
    send(1'b0, 16'(DP + 5), {64{1'b1}}, 8'hFF);
    send(1'b1, 16'hFFFF, '0, 8'h00);
    drain();

`ifdef UX607_DLM_CTRL_LS_EN
    repeat (8) @(posedge clk);
    #1;
    chk("ls_early", {63'd0, ram_ls}, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("ls_asleep", {63'd0, ram_ls}, 64'd1);
    a0 = n_acc;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h0010;
    @(negedge clk);
    chk("ls_hold_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    chk("ls_wake_ls", {63'd0, ram_ls}, 64'd0);
    chk("ls_wake_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    chk("ls_run_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("ls_wake_accepts", 64'(n_acc - a0), 64'd1);
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("ls_asleep2", {63'd0, ram_ls}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("ls_rst_ls", {63'd0, ram_ls}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ls_rst_run", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    send(1'b1, 16'h0010, '0, 8'h00);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
